// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: opcode set, instruction-word field
// widths and the issuer FSM state type.
package alu_pkg;

   localparam int OP_W    = 4;
   localparam int OPND_W  = 4;
   localparam int INSTR_W = OP_W + 2*OPND_W;
   localparam int SUM_W   = 4;
   localparam int RSP_W   = SUM_W + 1;

   typedef enum logic [OP_W-1:0] {
      OP_XOR = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_SHR = 4'd3
   } op_e;

   // Highest opcode the ALU implements.
   localparam logic [OP_W-1:0] OP_MAX = OP_SHR;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRIVE   = 2'd1,
      S_CAPTURE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Result FIFO: DEPTH entries (power of two) of WIDTH bits, head exposed
// combinationally, push and pop allowed in the same cycle.
module alu_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_pop_data,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;
   logic             w_push;
   logic             w_empty;

   assign w_empty = (r_count == '0);
   // A pop on an empty FIFO is ignored; a push is only taken with room,
   // counting the slot freed by a simultaneous pop.
   assign w_pop   = i_pop && !w_empty;
   assign w_push  = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

   // Storage write; contents need no reset because the head is masked when empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   // Pointers wrap naturally at DEPTH; count tracks push/pop balance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count    = r_count;

endmodule

// File: rtl/alu_issuer.sv
// ALU issuer: accepts {op,a,b} requests, drives the instruction word to an
// external combinational ALU, captures its result one cycle later and queues
// it in a response FIFO.
// Optional build macro ALU_ISSUER_OPCHK_EN: opcodes above OP_MAX are rejected
// without touching alu_in and produce an error response after one cycle.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | waiting for a request; ready when the FIFO has room
//   S_DRIVE   | alu_in stable, ALU output settling
//   S_CAPTURE | push ALU result (or error response) into the FIFO
module alu_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [OP_W-1:0]         req_op,
   input  logic [OPND_W-1:0]       req_a,
   input  logic [OPND_W-1:0]       req_b,
   output logic [INSTR_W-1:0]      alu_in,
   input  logic [SUM_W-1:0]        alu_sum,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [SUM_W-1:0]        rsp_sum,
   output logic                    rsp_err,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_run;
   logic [INSTR_W-1:0]  r_alu_in;
   logic                w_ready;
   logic                w_accept;
   logic                w_push;
   logic                w_bad_op;
   logic [RSP_W-1:0]    w_push_data;
   logic [RSP_W-1:0]    w_head;
   logic [CNT_W-1:0]    w_count;

`ifdef ALU_ISSUER_OPCHK_EN
   logic                r_err;

   assign w_bad_op    = (req_op > OP_MAX);
   assign w_push_data = r_err ? {{SUM_W{1'b0}}, 1'b1} : {alu_sum, 1'b0};
`else
   assign w_bad_op    = 1'b0;
   assign w_push_data = {alu_sum, 1'b0};
`endif

   // Next-state, handshake and push decode.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_accept    = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // r_run holds ready low throughout reset and releases it on the first edge.
            w_ready = r_run && (w_count < CNT_W'(DEPTH));
            if (w_ready && req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_bad_op ? S_CAPTURE : S_DRIVE;
            end
         end
         S_DRIVE: begin
            w_state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register, instruction word and run flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_run    <= 1'b0;
         r_alu_in <= '0;
`ifdef ALU_ISSUER_OPCHK_EN
         r_err    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
         if (w_accept && !w_bad_op) r_alu_in <= {req_op, req_a, req_b};
`ifdef ALU_ISSUER_OPCHK_EN
         if (w_accept) r_err <= w_bad_op;
`endif
      end
   end

   alu_rsp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RSP_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (rsp_ready),
      .o_pop_data  (w_head),
      .o_count     (w_count)
   );

   assign req_ready = w_ready;
   assign alu_in    = r_alu_in;
   assign rsp_valid = (w_count != '0);
   assign rsp_sum   = w_head[RSP_W-1:1];
   // Error bit is only ever pushed as 1 when opcode checking is built in.
   assign rsp_err   = w_head[0];
   assign occupancy = w_count;

endmodule
